// File: rtl/cs_host_initiator_pkg.sv
// Shared types and default widths for the host initiator, its stats counters and the host interface.
package cs_pkg;

   localparam int CS_ADDR_W = 8;
   localparam int CS_DATA_W = 16;

   typedef enum logic [1:0] {
      CS_READ  = 2'd0,
      CS_WRITE = 2'd1,
      CS_ADD   = 2'd2,
      CS_SUB   = 2'd3
   } cs_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_TURN  = 2'd2
   } cs_state_t;

   // Compute ops never touch DQ, so they may be issued back to back.
   function automatic logic is_compute(cs_op_t op);
      return (op == CS_ADD) || (op == CS_SUB);
   endfunction

endpackage

// File: rtl/cs_host_initiator_if.sv
// Host-side request/response channel of the initiator.
// Handshake: a beat transfers on a rising edge with valid && ready; the sender holds valid and payload
// stable until that edge, and valid never waits for ready.
interface cs_host_initiator_if
   import cs_pkg::*;
#(
   parameter int ADDR_W = CS_ADDR_W,
   parameter int DATA_W = CS_DATA_W
);

   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr_a;
   logic [ADDR_W-1:0] req_addr_b;
   logic [ADDR_W-1:0] req_addr_c;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output req_valid, req_op, req_addr_a, req_addr_b, req_addr_c, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_op, req_addr_a, req_addr_b, req_addr_c, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/cs_host_initiator_stats.sv
// Saturating per-op issue counters; only compiled and instantiated when CS_HOST_STATS_EN is defined.
`ifdef CS_HOST_STATS_EN
module cs_host_stats
   import cs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        issue,
   input  cs_op_t      op,
   output logic [15:0] stat_rd,
   output logic [15:0] stat_wr,
   output logic [15:0] stat_add,
   output logic [15:0] stat_sub
);

   function automatic logic [15:0] sat_inc(logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_rd  <= '0;
         stat_wr  <= '0;
         stat_add <= '0;
         stat_sub <= '0;
      end else if (issue) begin
         case (op)
            CS_READ:  stat_rd  <= sat_inc(stat_rd);
            CS_WRITE: stat_wr  <= sat_inc(stat_wr);
            CS_ADD:   stat_add <= sat_inc(stat_add);
            default:  stat_sub <= sat_inc(stat_sub);
         endcase
      end
   end

endmodule
`endif

// File: rtl/cs_host_initiator.sv
// Host initiator: turns host requests into one-cycle device commands on cmd/addA/addB/addC/DQ.
// Optional per-op issue counters are built when CS_HOST_STATS_EN is defined.
module cs_host_initiator
   import cs_pkg::*;
#(
   parameter int ADDR_W = CS_ADDR_W,
   parameter int DATA_W = CS_DATA_W
) (
   input  logic                clk,
   input  logic                reset,
   cs_host_initiator_if.slave  host,
   output logic [1:0]          cmd,
   output logic [ADDR_W-1:0]   addA,
   output logic [ADDR_W-1:0]   addB,
   output logic [ADDR_W-1:0]   addC,
   inout  wire  [DATA_W-1:0]   DQ,
   output cs_state_t           state_dbg,
   output logic                dq_oe
`ifdef CS_HOST_STATS_EN
   ,
   output logic [15:0]         stat_rd,
   output logic [15:0]         stat_wr,
   output logic [15:0]         stat_add,
   output logic [15:0]         stat_sub
`endif
);

   cs_state_t         state;
   cs_state_t         state_nxt;
   cs_op_t            op_q;
   logic [ADDR_W-1:0] a_q;
   logic [ADDR_W-1:0] b_q;
   logic [ADDR_W-1:0] c_q;
   logic [DATA_W-1:0] wd_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_valid_q;
   logic              run_q;
   logic              req_ready;
   logic              accept;

   assign accept         = host.req_valid && req_ready;
   assign host.req_ready = req_ready;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_data  = rsp_data_q;
   assign state_dbg      = state;
   assign DQ             = dq_oe ? wd_q : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            if (op_q == CS_WRITE)      state_nxt = ST_TURN;
            else if (op_q == CS_READ)  state_nxt = ST_IDLE;
            else                       state_nxt = accept ? ST_ISSUE : ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // run_q keeps req_ready low until the first edge after reset release.
   always_comb begin
      req_ready = 1'b0;
      cmd       = CS_READ;
      addA      = '0;
      addB      = '0;
      addC      = '0;
      dq_oe     = 1'b0;
      case (state)
         ST_IDLE:  req_ready = run_q && !rsp_valid_q;
         ST_ISSUE: begin
            cmd   = op_q;
            addA  = a_q;
            addB  = b_q;
            addC  = c_q;
            dq_oe = (op_q == CS_WRITE);
            if (is_compute(op_q)) req_ready = run_q && !rsp_valid_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_q       <= 1'b0;
         op_q        <= CS_READ;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         wd_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         run_q <= 1'b1;
         if (accept) begin
            op_q <= cs_op_t'(host.req_op);
            a_q  <= host.req_addr_a;
            b_q  <= host.req_addr_b;
            c_q  <= host.req_addr_c;
            wd_q <= host.req_wdata;
         end
         // A READ is only accepted with the slot empty, so set and clear never collide.
         if (state == ST_ISSUE && op_q == CS_READ) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= DQ;
         end else if (rsp_valid_q && host.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

`ifdef CS_HOST_STATS_EN
   cs_host_stats u_stats (
      .clk      (clk),
      .reset    (reset),
      .issue    (state == ST_ISSUE),
      .op       (op_q),
      .stat_rd  (stat_rd),
      .stat_wr  (stat_wr),
      .stat_add (stat_add),
      .stat_sub (stat_sub)
   );
`endif

endmodule

// File: tb/tb_cs_host_initiator.sv
// Directed bench for cs_host_initiator with a behavioural device memory and a command/response scoreboard.
module tb_cs_host_initiator;
   import cs_pkg::*;

   localparam int AW = 8;
   localparam int DW = 16;

   typedef struct packed {
      logic [1:0]    op;
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      logic [AW-1:0] c;
      logic [DW-1:0] wd;
   } cmd_t;

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cs_host_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) host_if ();

   logic [1:0]    cmd;
   logic [AW-1:0] add_a, add_b, add_c;
   wire  [DW-1:0] dq;
   cs_state_t     state_dbg;
   logic          dq_oe;
`ifdef CS_HOST_STATS_EN
   logic [15:0]   stat_rd, stat_wr, stat_add, stat_sub;
`endif

   cs_host_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .host      (host_if),
      .cmd       (cmd),
      .addA      (add_a),
      .addB      (add_b),
      .addC      (add_c),
      .DQ        (dq),
      .state_dbg (state_dbg),
      .dq_oe     (dq_oe)
`ifdef CS_HOST_STATS_EN
      ,
      .stat_rd   (stat_rd),
      .stat_wr   (stat_wr),
      .stat_add  (stat_add),
      .stat_sub  (stat_sub)
`endif
   );

   // behavioural device: drives read data whenever the host is not driving DQ
   logic [DW-1:0] mem [256] = '{default: 16'h0000};
   assign dq = dq_oe ? {DW{1'bz}} : mem[add_a];
   always @(posedge clk) begin
      case (cmd)
         2'd1: mem[add_c] <= dq;
         2'd2: mem[add_c] <= mem[add_a] + mem[add_b];
         2'd3: mem[add_c] <= mem[add_a] - mem[add_b];
         default: ;
      endcase
   end

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_rd_sent = 0;
   always @(posedge clk) cyc <= cyc + 1;

   cmd_t          cmd_q[$];
   logic [DW-1:0] exp_q[$];
   cmd_t          mon_e;
   logic [DW-1:0] mon_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // driver: call in the high phase (posedge+1); returns at posedge+1 after the accept edge
   task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] c, input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
      bit rdy;
      int n;
      host_if.req_valid  = 1'b1;
      host_if.req_op     = op;
      host_if.req_addr_a = a;
      host_if.req_addr_b = b;
      host_if.req_addr_c = c;
      host_if.req_wdata  = wd;
      rdy = 1'b0;
      n = 0;
      while (!rdy && n < 60) begin
         @(negedge clk);
         rdy = host_if.req_ready;
         @(posedge clk);
         #1;
         n++;
      end
      host_if.req_valid = 1'b0;
      if (!rdy) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else begin
         cmd_q.push_back('{op: op, a: a, b: b, c: c, wd: wd});
         if (op == CS_READ) begin
            exp_q.push_back(exp_rd);
            n_rd_sent++;
         end
      end
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("rsp_drain", exp_q.size(), 0);
   endtask

   // monitor: device-bus commands and host responses, sampled on the falling edge
   always @(negedge clk) begin
      if (state_dbg == ST_ISSUE) begin
         if (cmd_q.size() == 0) begin
            check("issue_unexpected", {cmd, add_a, add_b, add_c}, 32'hFFFF_FFFF);
         end else begin
            mon_e = cmd_q.pop_front();
            check("issue_cmd", {cmd, add_a, add_b, add_c}, {mon_e.op, mon_e.a, mon_e.b, mon_e.c});
            if (mon_e.op == CS_WRITE) check("dq_write", {dq_oe, dq}, {1'b1, mon_e.wd});
            else                      check("dq_oe_issue", dq_oe, 0);
         end
      end else begin
         check("bus_quiet", {dq_oe, cmd, add_a, add_b, add_c}, 0);
      end
      if (host_if.rsp_valid && host_if.rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", host_if.rsp_data, 32'hFFFF_FFFF);
         end else begin
            mon_d = exp_q.pop_front();
            check("rsp_data", host_if.rsp_data, mon_d);
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      host_if.req_valid  = 1'b0;
      host_if.req_op     = 2'd0;
      host_if.req_addr_a = '0;
      host_if.req_addr_b = '0;
      host_if.req_addr_c = '0;
      host_if.req_wdata  = '0;
      host_if.rsp_ready  = 1'b1;

      // reset state
      #1;
      check("rst_ready", host_if.req_ready, 0);
      check("rst_rsp_valid", host_if.rsp_valid, 0);
      check("rst_rsp_data", host_if.rsp_data, 0);
      check("rst_state", state_dbg, ST_IDLE);
      check("rst_bus", {dq_oe, cmd, add_a, add_b, add_c}, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1 check("rel_ready_pre_edge", host_if.req_ready, 0);
      @(posedge clk); #1;
      check("rel_ready_post_edge", host_if.req_ready, 1);

      // WRITE [0x10]=ABCD, TURN, then READ it back with 2-cycle latency
      send(CS_WRITE, 8'h00, 8'h00, 8'h10, 16'hABCD, 16'h0);
      check("wr_issue_ready", host_if.req_ready, 0);
      @(posedge clk); #1;
      check("turn_state", state_dbg, ST_TURN);
      check("turn_dq_oe", dq_oe, 0);
      check("turn_ready", host_if.req_ready, 0);
      send(CS_READ, 8'h10, 8'h00, 8'h00, 16'h0, 16'hABCD);
      check("rd_issue_ready", host_if.req_ready, 0);
      check("rd_lat_cycle1", host_if.rsp_valid, 0);
      @(posedge clk); #1;
      check("rd_lat_cycle2", host_if.rsp_valid, 1);
      check("rd_blocks_ready", host_if.req_ready, 0);
      wait_drain();

      // back-to-back ADD then SUB
      send(CS_WRITE, 8'h00, 8'h00, 8'h01, 16'd5, 16'h0);
      send(CS_WRITE, 8'h00, 8'h00, 8'h02, 16'd3, 16'h0);
      send(CS_ADD, 8'h01, 8'h02, 8'h03, 16'h0, 16'h0);
      begin
         int c0;
         c0 = cyc;
         check("add_issue_ready", host_if.req_ready, 1);
         send(CS_SUB, 8'h01, 8'h02, 8'h04, 16'h0, 16'h0);
         check("b2b_cycles", cyc - c0, 1);
      end
      send(CS_READ, 8'h03, 8'h00, 8'h00, 16'h0, 16'd8);
      send(CS_READ, 8'h04, 8'h00, 8'h00, 16'h0, 16'd2);
      wait_drain();

      // address boundaries and device-side wrap: 0 - 1 -> FFFF
      send(CS_WRITE, 8'h00, 8'h00, 8'h00, 16'd0, 16'h0);
      send(CS_WRITE, 8'h00, 8'h00, 8'hFF, 16'd1, 16'h0);
      send(CS_SUB, 8'h00, 8'hFF, 8'h07, 16'h0, 16'h0);
      send(CS_READ, 8'h07, 8'h00, 8'h00, 16'h0, 16'hFFFF);
      send(CS_READ, 8'hFF, 8'h00, 8'h00, 16'h0, 16'h0001);
      wait_drain();

      // response back-pressure with a second READ pending
      host_if.rsp_ready = 1'b0;
      send(CS_READ, 8'h10, 8'h00, 8'h00, 16'h0, 16'hABCD);
      fork
         send(CS_READ, 8'h03, 8'h00, 8'h00, 16'h0, 16'd8);
         begin
            for (int k = 0; k < 10 && !host_if.rsp_valid; k++) @(negedge clk);
            check("stall_valid_seen", host_if.rsp_valid, 1);
            repeat (5) begin
               @(negedge clk);
               check("stall_valid", host_if.rsp_valid, 1);
               check("stall_data", host_if.rsp_data, 16'hABCD);
               check("stall_ready", host_if.req_ready, 0);
            end
            @(posedge clk); #1;
            host_if.rsp_ready = 1'b1;
         end
      join
      wait_drain();

      // reset in the middle of a WRITE issue cycle
      host_if.req_valid  = 1'b1;
      host_if.req_op     = CS_WRITE;
      host_if.req_addr_a = 8'h00;
      host_if.req_addr_b = 8'h00;
      host_if.req_addr_c = 8'h20;
      host_if.req_wdata  = 16'h1234;
      @(negedge clk);
      check("abort_acc_ready", host_if.req_ready, 1);
      @(posedge clk); #2;
      host_if.req_valid = 1'b0;
      reset = 1'b0;
      n_rd_sent = 0;
      #1;
      check("abort_dq_oe", dq_oe, 0);
      check("abort_bus", {cmd, add_a, add_b, add_c}, 0);
      check("abort_state", state_dbg, ST_IDLE);
      check("abort_rsp_valid", host_if.rsp_valid, 0);
      check("abort_rsp_data", host_if.rsp_data, 0);
      check("abort_ready", host_if.req_ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1 check("abort_rel_pre_edge", host_if.req_ready, 0);
      @(posedge clk); #1;
      check("abort_rel_post_edge", host_if.req_ready, 1);
      send(CS_READ, 8'h20, 8'h00, 8'h00, 16'h0, 16'h0000);
      send(CS_READ, 8'h02, 8'h00, 8'h00, 16'h0, 16'd3);
      wait_drain();

`ifdef CS_HOST_STATS_EN
      check("stat_rd_before", stat_rd, n_rd_sent);
      for (int i = 0; i < 70000; i++) send(CS_ADD, 8'h01, 8'h02, 8'h09, 16'h0, 16'h0);
      @(posedge clk); #1;
      check("stat_add_sat", stat_add, 16'hFFFF);
      check("stat_rd_after", stat_rd, n_rd_sent);
`endif

      repeat (2) @(posedge clk);
      #1;
      check("cmd_q_empty", cmd_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cs_host_initiator.md
CS_HOST_INITIATOR -- requirements
Module: cs_host_initiator

Interface
REQ-001 Parameter ADDR_W, 8, device address width (addA/addB/addC).
REQ-002 Parameter DATA_W, 16, DQ data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  request accepted on a cycle with req_valid && req_ready.
REQ-007 req_op  input  2  0 READ, 1 WRITE, 2 ADD, 3 SUB.
REQ-008 req_addr_a / req_addr_b / req_addr_c  input  ADDR_W each  operand A, operand B, destination.
REQ-009 req_wdata  input  DATA_W  WRITE data.
REQ-010 rsp_valid  output  1  READ data available; held until rsp_ready.
REQ-011 rsp_ready  input  1  response consumed on a cycle with rsp_valid && rsp_ready.
REQ-012 rsp_data  output  DATA_W  captured READ data.
REQ-013 cmd  output  2  device command; addA, addB, addC  output  ADDR_W  device addresses.
REQ-014 DQ  inout  DATA_W  shared device data bus; driven only in a WRITE issue cycle, else high-Z.

Function
REQ-015 The FSM SHALL use the states IDLE, ISSUE and TURN.
REQ-016 IDLE: cmd=0 (READ, harmless), all addresses 0, DQ high-Z; req_ready = !rsp_valid.
REQ-017 On accept, the request SHALL be registered and the FSM SHALL enter ISSUE on the next cycle.
REQ-018 ISSUE: for exactly one cycle, cmd/addA/addB/addC SHALL present the registered op and addresses.
REQ-019 ISSUE with WRITE: DQ SHALL be driven with the registered wdata; the next state SHALL be TURN.
REQ-020 TURN: one cycle, DQ high-Z, cmd=0, req_ready=0, then IDLE (bus turnaround before any device drive).
REQ-021 ISSUE with READ: DQ SHALL be sampled at the edge ending ISSUE into rsp_data, rsp_valid set; latency accept-to-rsp_valid = 2 cycles.
REQ-022 ISSUE with ADD/SUB: req_ready = !rsp_valid; an accept here SHALL go straight to ISSUE (back-to-back compute, 1 op/cycle); otherwise IDLE.
REQ-023 ISSUE with READ or WRITE: req_ready SHALL be 0.
REQ-024 rsp_valid SHALL stay 1 with rsp_data stable until rsp_ready; rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-025 A READ SHALL NOT be issued while rsp_valid=1 (single response slot, no overflow).
REQ-026 The host SHALL perform no arithmetic; ADD/SUB results and DATA_W wrap-around are device-side.
REQ-027 Address 0 and address 2^ADDR_W-1 SHALL be issued unmodified; no address checking.

Reset
REQ-028 Reset assertion SHALL immediately, without a clock edge, force IDLE, cmd=0, addresses 0, DQ high-Z, req_ready=0, rsp_valid=0, rsp_data=0.
REQ-029 Reset during ISSUE/TURN SHALL abort the op with no response; req_ready SHALL rise on the first clk edge after deassertion.

Configuration
REQ-030 With CS_HOST_STATS_EN defined: outputs stat_rd, stat_wr, stat_add, stat_sub (16 bits each), incremented per ISSUE of that op, saturating at 16'hFFFF, cleared by reset.
REQ-031 Without CS_HOST_STATS_EN: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-032 Package cs_pkg SHALL hold the op enum (CS_READ=0, CS_WRITE=1, CS_ADD=2, CS_SUB=3), the FSM state enum, and the default ADDR_W/DATA_W constants.
REQ-033 Counters SHALL live in sub-module cs_host_stats, instantiated only under CS_HOST_STATS_EN.

Verification
REQ-034 WRITE a_c=8'h10 data=16'hABCD, then READ a_a=8'h10 -> one DQ-driven cycle with 16'hABCD, TURN cycle with DQ=Z, rsp_data=16'hABCD.
REQ-035 WRITE [1]=5, [2]=3; ADD c=3 then SUB c=4 back-to-back with req_valid held -> consecutive cmd 2 then 3; READ [3]=8, READ [4]=2.
REQ-036 READ issued, rsp_ready=0 for 5 cycles with second READ pending -> rsp_valid/rsp_data stable, req_ready=0, no second read cmd until handshake.
REQ-037 Reset asserted mid-ISSUE of WRITE -> DQ Z immediately, rsp_valid=0, the device memory location is not written by a later issue.
REQ-038 SUB [0]=0 minus [255]=1 into [7] -> READ [7] returns 16'hFFFF (device wrap).
REQ-039 With CS_HOST_STATS_EN, 70000 ADDs -> stat_add=16'hFFFF, stat_rd unchanged.
